// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: button/tick/miss events in, ball control, scores and winner out.
// Optional pause button and PAUSED state are enabled by defining PONG_MATCH_CTRL_PAUSE_EN.
module pong_match_ctrl #(
  parameter int WIN_SCORE          = 7,
  parameter int SCORE_W            = 4,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int POINT_PAUSE_FRAMES = 90,
  parameter int FRAME_CNT_W        = 8
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iFRAME_TICK,
  input  logic               iP1_BTN,
  input  logic               iP2_BTN,
`ifdef PONG_MATCH_CTRL_PAUSE_EN
  input  logic               iPAUSE_BTN,
`endif
  input  logic               iMISS_L,
  input  logic               iMISS_R,
  output logic               oBALL_RUN,
  output logic               oBALL_RESET,
  output logic               oSERVE_DIR,
  output logic [SCORE_W-1:0] oSCORE_L,
  output logic [SCORE_W-1:0] oSCORE_R,
  output logic [1:0]         oWINNER,
  output logic [2:0]         oSTATE
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
`ifdef PONG_MATCH_CTRL_PAUSE_EN
    ST_GAME_OVER = 3'd4,
    ST_PAUSED    = 3'd5
`else
    ST_GAME_OVER = 3'd4
`endif
  } state_t;

`ifdef PONG_MATCH_CTRL_PAUSE_EN
  localparam int NBTN = 3;
`else
  localparam int NBTN = 2;
`endif

  localparam logic [SCORE_W-1:0]     WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [FRAME_CNT_W-1:0] SERVE_CNT = FRAME_CNT_W'(SERVE_DELAY_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] POINT_CNT = FRAME_CNT_W'(POINT_PAUSE_FRAMES);

  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] sync1_q, sync2_q, sync3_q, rise_q;
  logic            btn_evt;
  logic            pause_evt;

`ifdef PONG_MATCH_CTRL_PAUSE_EN
  assign btn_raw   = {iPAUSE_BTN, iP2_BTN, iP1_BTN};
  assign pause_evt = rise_q[2];
`else
  assign btn_raw   = {iP2_BTN, iP1_BTN};
  assign pause_evt = 1'b0;
`endif
  // Both player buttons map onto one start event.
  assign btn_evt = rise_q[0] | rise_q[1];

  state_t                 state_q, state_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d, frame_cnt_inc;
  logic                   run_q, run_d;
  logic                   rst_pulse_q, rst_pulse_d;
  logic                   dir_q, dir_d;
  logic [SCORE_W-1:0]     score_l_q, score_l_d;
  logic [SCORE_W-1:0]     score_r_q, score_r_d;
  logic [1:0]             winner_q, winner_d;

  assign frame_cnt_inc = frame_cnt_q + FRAME_CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    run_d       = run_q;
    rst_pulse_d = 1'b0;
    dir_d       = dir_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    winner_d    = winner_q;

    case (state_q)
      ST_IDLE: begin
        run_d = 1'b0;
        if (btn_evt) begin
          score_l_d   = '0;
          score_r_d   = '0;
          dir_d       = 1'b1;
          rst_pulse_d = 1'b1;
          state_d     = ST_SERVE;
        end
      end
      ST_SERVE: begin
        run_d = 1'b0;
        if (iFRAME_TICK) begin
          frame_cnt_d = frame_cnt_inc;
          if (frame_cnt_inc == SERVE_CNT) begin
            state_d = ST_PLAY;
            run_d   = 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (iMISS_L && iMISS_R) begin
          // Simultaneous misses replay the point without scoring.
          run_d   = 1'b0;
          state_d = ST_POINT;
        end else if (iMISS_L) begin
          if (score_r_q != WIN_VAL) score_r_d = score_r_q + SCORE_W'(1);
          dir_d   = 1'b0;
          run_d   = 1'b0;
          state_d = ST_POINT;
        end else if (iMISS_R) begin
          if (score_l_q != WIN_VAL) score_l_d = score_l_q + SCORE_W'(1);
          dir_d   = 1'b1;
          run_d   = 1'b0;
          state_d = ST_POINT;
`ifdef PONG_MATCH_CTRL_PAUSE_EN
        end else if (pause_evt) begin
          run_d   = 1'b0;
          state_d = ST_PAUSED;
`endif
        end
      end
      ST_POINT: begin
        run_d = 1'b0;
        if (iFRAME_TICK) begin
          frame_cnt_d = frame_cnt_inc;
          if (frame_cnt_inc == POINT_CNT) begin
            if (score_l_q == WIN_VAL) begin
              winner_d = 2'b01;
              state_d  = ST_GAME_OVER;
            end else if (score_r_q == WIN_VAL) begin
              winner_d = 2'b10;
              state_d  = ST_GAME_OVER;
            end else begin
              rst_pulse_d = 1'b1;
              state_d     = ST_SERVE;
            end
          end
        end
      end
      ST_GAME_OVER: begin
        run_d = 1'b0;
        if (btn_evt) begin
          score_l_d   = '0;
          score_r_d   = '0;
          winner_d    = 2'b00;
          dir_d       = 1'b1;
          rst_pulse_d = 1'b1;
          state_d     = ST_SERVE;
        end
      end
`ifdef PONG_MATCH_CTRL_PAUSE_EN
      ST_PAUSED: begin
        run_d = 1'b0;
        if (pause_evt) begin
          run_d   = 1'b1;
          state_d = ST_PLAY;
        end
      end
`endif
      default: begin
        run_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Every state entry starts its frame count from zero.
    if (state_d != state_q) frame_cnt_d = '0;
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      rise_q      <= '0;
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      run_q       <= 1'b0;
      rst_pulse_q <= 1'b0;
      dir_q       <= 1'b1;
      score_l_q   <= '0;
      score_r_q   <= '0;
      winner_q    <= 2'b00;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      rise_q      <= sync2_q & ~sync3_q;
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      run_q       <= run_d;
      rst_pulse_q <= rst_pulse_d;
      dir_q       <= dir_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      winner_q    <= winner_d;
    end
  end

  assign oBALL_RUN   = run_q;
  assign oBALL_RESET = rst_pulse_q;
  assign oSERVE_DIR  = dir_q;
  assign oSCORE_L    = score_l_q;
  assign oSCORE_R    = score_r_q;
  assign oWINNER     = winner_q;
  assign oSTATE      = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with a per-cycle reference model and literal checkpoints.
module tb_pong_match_ctrl;
  localparam int WIN   = 3;
  localparam int SW    = 4;
  localparam int SERVE = 2;
  localparam int PAUSE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, p1 = 1'b0, p2 = 1'b0, pbtn = 1'b0, ml = 1'b0, mr = 1'b0;
  logic ball_run, ball_rst, serve_dir;
  logic [SW-1:0] score_l, score_r;
  logic [1:0] winner;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pong_match_ctrl #(
    .WIN_SCORE(WIN), .SCORE_W(SW), .SERVE_DELAY_FRAMES(SERVE),
    .POINT_PAUSE_FRAMES(PAUSE), .FRAME_CNT_W(8)
  ) dut (
    .iCLK(clk), .iRESET(rst), .iFRAME_TICK(tick), .iP1_BTN(p1), .iP2_BTN(p2),
`ifdef PONG_MATCH_CTRL_PAUSE_EN
    .iPAUSE_BTN(pbtn),
`endif
    .iMISS_L(ml), .iMISS_R(mr),
    .oBALL_RUN(ball_run), .oBALL_RESET(ball_rst), .oSERVE_DIR(serve_dir),
    .oSCORE_L(score_l), .oSCORE_R(score_r), .oWINNER(winner), .oSTATE(state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: match rules evaluated per clock edge. A button level
  // sampled at edge E acts at edge E+3 when the previous sample was low.
  int m_state = 0, m_cnt = 0, m_sl = 0, m_sr = 0, m_win = 0;
  bit m_run = 0, m_rst = 0, m_dir = 1;
  bit [4:0] h1 = '0, h2 = '0, hp = '0;

  always @(posedge clk) begin
    bit ev, pev;
    int nxt;
    if (rst) begin
      h1 = '0; h2 = '0; hp = '0;
      m_state = 0; m_cnt = 0; m_sl = 0; m_sr = 0; m_win = 0;
      m_run = 0; m_rst = 0; m_dir = 1;
    end else begin
      h1 = {h1[3:0], p1};
      h2 = {h2[3:0], p2};
      hp = {hp[3:0], pbtn};
      ev  = (h1[3] && !h1[4]) || (h2[3] && !h2[4]);
`ifdef PONG_MATCH_CTRL_PAUSE_EN
      pev = hp[3] && !hp[4];
`else
      pev = 1'b0;
`endif
      m_rst = 0;
      nxt = m_state;
      if (m_state == 0 || m_state == 4) begin
        if (ev) begin
          m_sl = 0; m_sr = 0; m_win = 0; m_dir = 1; m_rst = 1; nxt = 1;
        end
      end else if (m_state == 1) begin
        if (tick) begin
          m_cnt++;
          if (m_cnt == SERVE) begin nxt = 2; m_run = 1; end
        end
      end else if (m_state == 2) begin
        if (ml || mr) begin
          if (ml && !mr) begin m_sr = (m_sr < WIN) ? m_sr + 1 : WIN; m_dir = 0; end
          if (mr && !ml) begin m_sl = (m_sl < WIN) ? m_sl + 1 : WIN; m_dir = 1; end
          m_run = 0; nxt = 3;
        end else if (pev) begin
          m_run = 0; nxt = 5;
        end
      end else if (m_state == 3) begin
        if (tick) begin
          m_cnt++;
          if (m_cnt == PAUSE) begin
            if (m_sl == WIN) begin m_win = 1; nxt = 4; end
            else if (m_sr == WIN) begin m_win = 2; nxt = 4; end
            else begin m_rst = 1; nxt = 1; end
          end
        end
      end else if (m_state == 5) begin
        if (pev) begin m_run = 1; nxt = 2; end
      end
      if (nxt != m_state) m_cnt = 0;
      m_state = nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("state",     state,     m_state);
      check("ball_run",  ball_run,  m_run);
      check("ball_reset", ball_rst, m_rst);
      check("serve_dir", serve_dir, m_dir);
      check("score_l",   score_l,   m_sl);
      check("score_r",   score_r,   m_sr);
      check("winner",    winner,    m_win);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1; @(negedge clk);
      tick = 1'b0; @(negedge clk);
    end
  endtask

  task automatic miss(input bit l, input bit r);
    ml = l; mr = r; @(negedge clk);
    ml = 1'b0; mr = 1'b0; @(negedge clk);
  endtask

  task automatic press(input int which);
    if (which == 1) p1 = 1'b1; else if (which == 2) p2 = 1'b1; else pbtn = 1'b1;
    @(negedge clk);
    p1 = 1'b0; p2 = 1'b0; pbtn = 1'b0;
    cyc(4);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
  endtask

  initial begin
    int nrst, ntr;
    logic [2:0] prev;
    cyc(2);
    chk_en = 1'b1;
    rst = 1'b0;
    cyc(1);
    check("lit_reset_state", state, 0);
    check("lit_reset_dir", serve_dir, 1);

    // Button edge latency: no change after N+2, SERVE after N+3.
    p1 = 1'b1; cyc(1); p1 = 1'b0; cyc(2);
    check("lit_latency_n2", state, 0);
    cyc(1);
    check("lit_latency_n3", state, 1);
    check("lit_latency_rst", ball_rst, 1);
    cyc(1);
    check("lit_rst_one_cycle", ball_rst, 0);

    ticks(SERVE);
    check("lit_play_state", state, 2);
    check("lit_play_run", ball_run, 1);

    miss(1, 0);
    check("lit_missl_sr", score_r, 1);
    check("lit_missl_dir", serve_dir, 0);
    check("lit_missl_state", state, 3);
    check("lit_missl_run", ball_run, 0);
    ticks(PAUSE);
    check("lit_point_to_serve", state, 1);
    ticks(SERVE);

    repeat (3) begin
      miss(0, 1);
      ticks(PAUSE);
      if (state == 3'd1) ticks(SERVE);
    end
    check("lit_sl_win", score_l, 3);
    check("lit_winner", winner, 1);
    check("lit_gameover", state, 4);
    miss(0, 1);
    miss(0, 1);
    check("lit_sl_held", score_l, 3);

    press(2);
    check("lit_restart_state", state, 1);
    check("lit_restart_sl", score_l, 0);
    check("lit_restart_winner", winner, 0);

    ticks(SERVE);
    miss(1, 1);
    check("lit_replay_state", state, 3);
    check("lit_replay_scores", {score_l, score_r}, 0);
    check("lit_replay_dir", serve_dir, 1);
    ticks(PAUSE);

    // Inputs that SERVE must ignore.
    press(1);
    press(2);
    miss(1, 0);
    miss(0, 1);
    check("lit_serve_ignore_state", state, 1);
    check("lit_serve_ignore_sr", score_r, 0);

    // Held button yields one transition.
    do_reset();
    nrst = 0; ntr = 0; prev = 3'd0;
    p1 = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (ball_rst === 1'b1) nrst++;
      if (state !== prev) ntr++;
      prev = state;
    end
    p1 = 1'b0;
    check("lit_hold_rst_pulses", nrst, 1);
    check("lit_hold_transitions", ntr, 1);

    // Build a 2-1 score, then reset in POINT.
    cyc(2);
    ticks(SERVE);
    miss(0, 1); ticks(PAUSE); ticks(SERVE);
    miss(0, 1); ticks(PAUSE); ticks(SERVE);
    miss(1, 0);
    check("lit_pre_reset_state", state, 3);
    check("lit_pre_reset_score", {score_l, score_r}, {4'd2, 4'd1});
    rst = 1'b1; cyc(1);
    check("lit_abort_state", state, 0);
    check("lit_abort_scores", {score_l, score_r}, 0);
    check("lit_abort_dir", serve_dir, 1);
    rst = 1'b0; cyc(1);

`ifdef PONG_MATCH_CTRL_PAUSE_EN
    press(1);
    ticks(SERVE);
    press(3);
    check("lit_paused", state, 5);
    miss(1, 0);
    check("lit_paused_miss", score_r, 0);
    press(3);
    check("lit_unpaused", state, 2);
    check("lit_unpaused_run", ball_run, 1);
`endif

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match-level sequencer for the Pong VGA game datapath.
- Takes player buttons, a per-frame tick and ball-miss events from the ball/paddle physics.
- Drives ball run/recentre control, serve direction, per-player scores and winner for the renderer.
- Runs in the 120 MHz game clock domain next to the VGA game core.

Parameters:
- WIN_SCORE, 7, points needed to win; must satisfy 1..(2^SCORE_W - 1).
- SCORE_W, 4, score counter width.
- SERVE_DELAY_FRAMES, 60, frame ticks between ball recentre and ball release; must be >= 1.
- POINT_PAUSE_FRAMES, 90, frame ticks of freeze after a point; must be >= 1.
- FRAME_CNT_W, 8, frame counter width; must hold max(SERVE_DELAY_FRAMES, POINT_PAUSE_FRAMES).

Ports:
- iCLK  in  1  game clock.
- iRESET  in  1  synchronous, active-high reset.
- iFRAME_TICK  in  1  one-cycle pulse per frame (vsync start), already in iCLK domain.
- iP1_BTN  in  1  left player start/serve button, asynchronous, active-high.
- iP2_BTN  in  1  right player start/serve button, asynchronous, active-high.
- iMISS_L  in  1  one-cycle pulse: ball passed the left paddle.
- iMISS_R  in  1  one-cycle pulse: ball passed the right paddle.
- oBALL_RUN  out  1  ball motion enable.
- oBALL_RESET  out  1  one-cycle pulse: recentre ball and paddles.
- oSERVE_DIR  out  1  0 = ball launches left, 1 = right.
- oSCORE_L  out  SCORE_W  left player score.
- oSCORE_R  out  SCORE_W  right player score.
- oWINNER  out  2  00 none, 01 left, 10 right.
- oSTATE  out  3  current state code, for debug and the renderer.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (iCLK, iRESET).
- Outputs:
  - All outputs are registered.
  - Reset values: oBALL_RUN=0, oBALL_RESET=0, oSERVE_DIR=1, scores=0, oWINNER=00, oSTATE=IDLE.
  - Reset asserted mid-match aborts immediately; a reset cycle takes priority over every other input.
- Buttons:
  - Each button passes a 2-FF synchronizer, then rising-edge detection.
  - A button rising before clock edge N changes oSTATE after edge N+3.
  - Holding a button generates no further events.
  - P1 and P2 edges are equivalent; both in the same cycle count as one event.
- Frame counter:
  - Cleared on every state entry.
  - Increments only on iFRAME_TICK.
  - Ticks are ignored in IDLE, PLAY and GAME_OVER.
- States (oSTATE code):
  - IDLE (0): on a button event, clear both scores, set oSERVE_DIR=1, pulse oBALL_RESET, go to SERVE.
  - SERVE (1): oBALL_RUN=0. On the tick that brings the count to SERVE_DELAY_FRAMES, go to PLAY with oBALL_RUN=1 in the same update.
  - PLAY (2):
    - iMISS_L: increment oSCORE_R, set oSERVE_DIR=0, go to POINT. oBALL_RUN drops in the same update.
    - iMISS_R: increment oSCORE_L, set oSERVE_DIR=1, go to POINT.
    - iMISS_L and iMISS_R in the same cycle: no score change, oSERVE_DIR unchanged, go to POINT (replay).
  - POINT (3): oBALL_RUN=0. On the tick that brings the count to POINT_PAUSE_FRAMES:
    - If a score equals WIN_SCORE: set oWINNER and go to GAME_OVER.
    - Otherwise: pulse oBALL_RESET and go to SERVE.
  - GAME_OVER (4):
    - oWINNER and scores are held.
    - A button event clears the scores, sets oWINNER=00, sets oSERVE_DIR=1, pulses oBALL_RESET and goes to SERVE.
- Ignored inputs:
  - Miss pulses outside PLAY.
  - Button events in SERVE, PLAY and POINT.
- Scores saturate at WIN_SCORE and never wrap.
- oBALL_RESET is high for exactly one cycle per pulse.
- Unused state codes recover to IDLE on the next cycle.

Optional Feature:
- Macro: PONG_MATCH_CTRL_PAUSE_EN.
- With the macro defined:
  - Adds input port iPAUSE_BTN (1 bit), synchronized and edge-detected like the player buttons.
  - An event in PLAY goes to PAUSED (5): oBALL_RUN=0, misses ignored.
  - An event in PAUSED returns to PLAY with oBALL_RUN=1.
  - Pause events in any other state are ignored.
- Without the macro: no iPAUSE_BTN port and code 5 is unreachable; 5 follows the unused-code rule.

Test Plan:
Bench parameters: WIN_SCORE=3, SERVE_DELAY_FRAMES=2, POINT_PAUSE_FRAMES=3.
- Reset, then iP1_BTN rising -> oBALL_RESET pulses once, oSTATE=1 three cycles after the edge. After the 2nd iFRAME_TICK: oSTATE=2, oBALL_RUN=1.
- In PLAY, pulse iMISS_L -> oSCORE_R=1, oSERVE_DIR=0, oBALL_RUN=0, oSTATE=3. After 3 ticks: oBALL_RESET pulse, oSTATE=1.
- Miss-right three times -> oSCORE_L=3. After the pause: oWINNER=01, oSTATE=4. Extra iMISS_R pulses leave the score at 3. iP2_BTN -> scores 0, oWINNER=00, oSTATE=1.
- iMISS_L and iMISS_R in the same cycle during PLAY -> scores unchanged, oSTATE=3, oSERVE_DIR unchanged.
- Button held high for 1000 cycles in IDLE -> exactly one transition. Buttons and misses in SERVE -> no effect.
- iRESET asserted in POINT with score 2-1 -> next cycle: all outputs at reset values, oSTATE=0. With PONG_MATCH_CTRL_PAUSE_EN: pause in PLAY -> oSTATE=5, miss ignored, second pause -> oSTATE=2.
